mmio_load_unit: RTL

Executes uncached, memory-mapped I/O loads issued by the load buffer. Takes one MMIO load at a time from the load-pipeline issue port, performs a single-beat read on the MMIO bus, and formats the returned word by size and sign. Returns the result to the writeback stage. Loads killed by branch flushes are dropped; a read already on the bus is drained first.

---
 rtl/mmio_load_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_load_unit.sv
// MMIO load unit: executes one uncached single-beat bus read at a time and formats the result.
// Optional bus-response timeout is enabled by defining MMIO_TIMEOUT_EN.
package mmio_load_unit_pkg;
  localparam int unsigned TAG_W = 7;
  localparam int unsigned SQN_W = 7;

  typedef logic [TAG_W-1:0] Tag;
  typedef logic [SQN_W-1:0] SqN;

  typedef enum logic [1:0] {
    AGU_NO_EXCEPTION  = 2'd0,
    AGU_ADDR_MISALIGN = 2'd1,
    AGU_ACCESS_FAULT  = 2'd2,
    AGU_PAGE_FAULT    = 2'd3
  } AGU_Exception;

  typedef struct packed {
    logic [31:0]  addr;
    logic [1:0]   size;
    logic         signExtend;
    Tag           tagDst;
    SqN           sqN;
    logic         doNotCommit;
    AGU_Exception exception;
    logic         isMMIO;
    logic         valid;
  } LD_UOp;

  typedef struct packed {
    SqN   sqN;
    logic taken;
  } BranchProv;

  // A taken branch flushes every op at or after its sqN (wrap-around compare).
  function automatic logic isFlushed(SqN opSqN, BranchProv br);
    SqN diff;
    diff = opSqN - br.sqN;
    return br.taken && !diff[SQN_W-1];
  endfunction
endpackage

module mmio_load_unit
  import mmio_load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  LD_UOp       IN_uopLd,
  input  BranchProv   IN_branch,
  output logic        OUT_stall,
  output logic        OUT_memReqValid,
  output logic [31:0] OUT_memReqAddr,
  input  logic        IN_memReqReady,
  input  logic        IN_memRespValid,
  input  logic [31:0] IN_memRespData,
  input  logic        IN_wbStall,
  output logic        OUT_resValid,
  output Tag          OUT_resTag,
  output SqN          OUT_resSqN,
  output logic [31:0] OUT_resData,
  output logic        OUT_resDoNotCommit,
  output logic        OUT_resFault
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} State;

  State        state, stateNext;
  logic        killed, killedNext;
  logic        accept, kill, timeout;
  logic [1:0]  ldLane;
  logic [1:0]  ldSize;
  logic        ldSignExt;
  SqN          ldSqN;
  logic [7:0]  respByte;
  logic [15:0] respHalf;
  logic [31:0] respFmt;

  if (TIMEOUT_CYCLES == 0) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  always_comb begin
    accept = IN_uopLd.valid && IN_uopLd.isMMIO &&
             (IN_uopLd.exception == AGU_NO_EXCEPTION) &&
             !isFlushed(IN_uopLd.sqN, IN_branch);
    kill   = isFlushed(ldSqN, IN_branch);
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] waitCnt;
  logic             resFault;

  // Counts cycles spent in WAIT; zero on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) waitCnt <= '0;
    else                      waitCnt <= waitCnt + CNT_W'(1);
  end

  assign timeout = (state == WAIT) && ((waitCnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) resFault <= 1'b0;
    else if (state == WAIT && stateNext == DONE) resFault <= !IN_memRespValid;
  end

  assign OUT_resFault = resFault;
`else
  assign timeout      = 1'b0;
  assign OUT_resFault = 1'b0;
`endif

  // Next-state logic; a kill in WAIT is remembered so the response is drained silently.
  always_comb begin
    stateNext  = state;
    killedNext = killed;
    case (state)
      IDLE: begin
        killedNext = 1'b0;
        if (accept) stateNext = REQ;
      end
      REQ: begin
        if (IN_memReqReady) begin
          stateNext  = WAIT;
          killedNext = kill;
        end else if (kill) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        if (kill) killedNext = 1'b1;
        if (IN_memRespValid || timeout) stateNext = (killed || kill) ? IDLE : DONE;
      end
      DONE: begin
        if (kill || !IN_wbStall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      killed          <= 1'b0;
      OUT_stall       <= 1'b0;
      OUT_memReqValid <= 1'b0;
      OUT_resValid    <= 1'b0;
    end else begin
      state           <= stateNext;
      killed          <= killedNext;
      OUT_stall       <= (stateNext != IDLE);
      OUT_memReqValid <= (stateNext == REQ);
      OUT_resValid    <= (stateNext == DONE);
    end
  end

  // Lane select and extension of the returned word.
  always_comb begin
    respByte = IN_memRespData[7:0];
    case (ldLane)
      2'd0:    respByte = IN_memRespData[7:0];
      2'd1:    respByte = IN_memRespData[15:8];
      2'd2:    respByte = IN_memRespData[23:16];
      default: respByte = IN_memRespData[31:24];
    endcase
    respHalf = ldLane[1] ? IN_memRespData[31:16] : IN_memRespData[15:0];
    case (ldSize)
      2'd0:    respFmt = {{24{ldSignExt & respByte[7]}}, respByte};
      2'd1:    respFmt = {{16{ldSignExt & respHalf[15]}}, respHalf};
      default: respFmt = IN_memRespData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      OUT_memReqAddr     <= {IN_uopLd.addr[31:2], 2'b00};
      ldLane             <= IN_uopLd.addr[1:0];
      ldSize             <= IN_uopLd.size;
      ldSignExt          <= IN_uopLd.signExtend;
      ldSqN              <= IN_uopLd.sqN;
      OUT_resTag         <= IN_uopLd.tagDst;
      OUT_resDoNotCommit <= IN_uopLd.doNotCommit;
    end
    if (state == WAIT && stateNext == DONE) OUT_resData <= IN_memRespValid ? respFmt : 32'h0;
  end

  assign OUT_resSqN = ldSqN;
endmodule
